// File: rtl/pad_oneshot_gen.sv
`default_nettype none
// ============================================================================
// Module   : pad_oneshot_gen
// Brief    : Paddle pulse responder for the Pong core. Emulates the two 555
//            monostable paddle circuits: every falling edge of the active-low
//            trigger starts one pulse per player. Each pulse lasts
//            BASE_CYCLES + position * STEP_CYCLES clocks.
//            Optional feature macro: PAD_BUTTON_EN. When it is defined, each
//            position comes from an up/down button register instead of the
//            direct PADx_POS inputs.
// Revision : 1.0 - initial release
// ============================================================================
module pad_oneshot_gen #(
    parameter int POS_W       = 8,
    parameter int BASE_CYCLES = 7280,
    parameter int STEP_CYCLES = 455,
    parameter int CNT_W       = 20,
    parameter int BTN_RATE    = 7159
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             PAD_TRG_N,
    input  logic [POS_W-1:0] PAD1_POS,
    input  logic [POS_W-1:0] PAD2_POS,
    input  logic             PAD1_UP_N,
    input  logic             PAD1_DN_N,
    input  logic             PAD2_UP_N,
    input  logic             PAD2_DN_N,
    output logic             PAD1_OUT,
    output logic             PAD2_OUT
);

    // Channel FSM encoding
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_PULSE = 1'b1;

    // Trigger synchronizer stages; s3 holds the previous synchronized value
    logic             r_trg_s1;
    logic             r_trg_s2;
    logic             r_trg_s3;
    logic             w_fall;

    // Per-channel position feeding the length calculation, and pulse outputs
    logic [POS_W-1:0] w_pos [2];
    logic [1:0]       w_out;

    // Synchronize the trigger and keep one cycle of history for edge detect
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_trg_s1 <= 1'b1;
            r_trg_s2 <= 1'b1;
            r_trg_s3 <= 1'b1;
        end else begin
            r_trg_s1 <= PAD_TRG_N;
            r_trg_s2 <= r_trg_s1;
            r_trg_s3 <= r_trg_s2;
        end
    end

    // A single-cycle strobe on the high-to-low transition of the synced trigger
    assign w_fall = r_trg_s3 & ~r_trg_s2;

`ifdef PAD_BUTTON_EN
    localparam int               c_TMR_W    = (BTN_RATE > 1) ? $clog2(BTN_RATE) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(BTN_RATE - 1);
    localparam logic [POS_W-1:0] c_POS_MID  = {1'b1, {(POS_W-1){1'b0}}};
    localparam logic [POS_W-1:0] c_POS_MAX  = {POS_W{1'b1}};

    logic [c_TMR_W-1:0] r_btn_tmr;
    logic               w_btn_tick;
    logic [1:0]         w_up_raw_n;
    logic [1:0]         w_dn_raw_n;
    logic               w_unused_pos;

    assign w_up_raw_n   = {PAD2_UP_N, PAD1_UP_N};
    assign w_dn_raw_n   = {PAD2_DN_N, PAD1_DN_N};
    assign w_unused_pos = ^{PAD1_POS, PAD2_POS};
    assign w_btn_tick   = (r_btn_tmr == c_TMR_LAST);

    // Shared free-running step timer, one tick every BTN_RATE cycles
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_btn_tmr <= '0;
        end else if (w_btn_tick) begin
            r_btn_tmr <= '0;
        end else begin
            r_btn_tmr <= r_btn_tmr + 1'b1;
        end
    end

    for (genvar gb = 0; gb < 2; gb++) begin : g_btn
        logic [1:0]       r_up_sync_n;
        logic [1:0]       r_dn_sync_n;
        logic [POS_W-1:0] r_pos;
        logic             w_up;
        logic             w_dn;

        assign w_up = ~r_up_sync_n[1];
        assign w_dn = ~r_dn_sync_n[1];

        // Two-flop synchronizers for the active-low buttons (idle high)
        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                r_up_sync_n <= 2'b11;
                r_dn_sync_n <= 2'b11;
            end else begin
                r_up_sync_n <= {r_up_sync_n[0], w_up_raw_n[gb]};
                r_dn_sync_n <= {r_dn_sync_n[0], w_dn_raw_n[gb]};
            end
        end

        // Saturating position step on each timer tick; both/neither holds
        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                r_pos <= c_POS_MID;
            end else if (w_btn_tick && (w_up ^ w_dn)) begin
                if (w_up && (r_pos != '0)) begin
                    r_pos <= r_pos - 1'b1;
                end else if (w_dn && (r_pos != c_POS_MAX)) begin
                    r_pos <= r_pos + 1'b1;
                end
            end
        end

        assign w_pos[gb] = r_pos;
    end
`else
    logic w_unused_btn;

    assign w_pos[0]     = PAD1_POS;
    assign w_pos[1]     = PAD2_POS;
    assign w_unused_btn = ^{PAD1_UP_N, PAD1_DN_N, PAD2_UP_N, PAD2_DN_N};
`endif

    for (genvar gc = 0; gc < 2; gc++) begin : g_chan
        logic [0:0]       r_state;
        logic [0:0]       w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic [CNT_W-1:0] w_len;
        logic             r_out;
        logic             w_out_nxt;

        // Pulse length from the position visible on the acceptance cycle
        assign w_len = CNT_W'(BASE_CYCLES)
                     + CNT_W'(w_pos[gc]) * CNT_W'(STEP_CYCLES);

        // State, counter and registered output
        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                r_state <= c_ST_IDLE;
                r_cnt   <= '0;
                r_out   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_out   <= w_out_nxt;
            end
        end

        // Non-retriggerable one-shot: falls seen while pulsing are dropped.
        // A count of 0 is also treated as the final cycle so a zero-length
        // configuration cannot wrap the counter into a huge pulse.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_out_nxt   = 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_fall) begin
                        w_state_nxt = c_ST_PULSE;
                        w_cnt_nxt   = w_len;
                        w_out_nxt   = 1'b1;
                    end
                end
                c_ST_PULSE: begin
                    w_out_nxt = 1'b1;
                    if (r_cnt <= CNT_W'(1)) begin
                        w_state_nxt = c_ST_IDLE;
                        w_cnt_nxt   = '0;
                        w_out_nxt   = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        assign w_out[gc] = r_out;
    end

    assign PAD1_OUT = w_out[0];
    assign PAD2_OUT = w_out[1];

endmodule
`default_nettype wire

// File: doc/pad_oneshot_gen.md
# pad_oneshot_gen

Paddle pulse responder for the Pong core: emulates the two 555 monostable paddle circuits that answer the core's active-low paddle trigger. On each trigger falling edge it drives PAD1_OUT and PAD2_OUT high for a duration proportional to each player's paddle position, which the core converts to a vertical paddle location. It sits between the player input pins and the core's PAD_TRG_N / PAD1_OUT / PAD2_OUT interface, clocked by the 7.159 MHz core clock.

## Interface
- POS_W, 8, paddle position width; position range 0..2^POS_W-1
- BASE_CYCLES, 7280, pulse length in CLK cycles at position 0 (16 lines of 455 clocks)
- STEP_CYCLES, 455, additional CLK cycles per position step (one scanline)
- CNT_W, 20, pulse counter width; BASE_CYCLES+(2^POS_W-1)*STEP_CYCLES must be < 2^CNT_W
- BTN_RATE, 7159, CLK cycles between button position steps (used only with PAD_BUTTON_EN)

- CLK  in  1  core clock, all logic on rising edge
- RESET_N  in  1  asynchronous active-low reset
- PAD_TRG_N  in  1  trigger from core, asynchronous to this block's view, falling edge starts pulses
- PAD1_POS  in  POS_W  player 1 direct position (0 = top)
- PAD2_POS  in  POS_W  player 2 direct position
- PAD1_UP_N, PAD1_DN_N  in  1 each  player 1 buttons, active low
- PAD2_UP_N, PAD2_DN_N  in  1 each  player 2 buttons, active low
- PAD1_OUT  out  1  player 1 pulse, registered
- PAD2_OUT  out  1  player 2 pulse, registered

## Operation
- PAD_TRG_N passes a 2-flop synchronizer (s1, s2) plus history flop s3; fall = s3 & ~s2. All three reset to 1.
- Each channel is an independent FSM, states IDLE and PULSE, with a CNT_W-bit down counter.
- IDLE: output 0. On fall: latch pos, load counter with L = BASE_CYCLES + pos*STEP_CYCLES (computed at CNT_W width, unsigned), go PULSE, output 1.
- PULSE: output 1, counter decrements each cycle; on the cycle counter == 1 the next state is IDLE and output becomes 0.
- A fall detected in PULSE, including the final cycle, is ignored (non-retriggerable). No gap-free back-to-back pulses.
- Trigger held low produces exactly one pulse; a new pulse requires PAD_TRG_N to return high for at least 2 cycles and then fall.
- Both channels start on the same fall. They end independently.
- Position is sampled only at trigger acceptance. Later position changes never alter a running pulse.

## Timing
- Reset: PAD1_OUT = PAD2_OUT = 0, both FSMs IDLE, counters 0, button positions = 2^(POS_W-1), rate timer 0. Reset asserted mid-pulse forces outputs 0 immediately (asynchronous). After release the block waits for a fresh fall.
- Latency: when PAD_TRG_N falls before rising edge n, PADx_OUT is high after edge n+2.
- Pulse width: exactly L CLK cycles.
- Position 0 gives BASE_CYCLES. Position 2^POS_W-1 gives the maximum. There is no wrap.

## Configuration
- PAD_BUTTON_EN defined:
  - Each channel uses an internal POS_W-bit position register driven by its UP_N/DN_N buttons, each synchronized by 2 flops. PADx_POS is ignored.
  - A shared free-running timer pulses once every BTN_RATE cycles. On that pulse:
    - UP only: position decrements toward top, saturating at 0.
    - DN only: position increments, saturating at 2^POS_W-1.
    - Both or neither: position holds.
  - Pulse L uses the register value on the acceptance cycle.
- PAD_BUTTON_EN undefined:
  - L uses PADx_POS sampled on the acceptance cycle.
  - Button inputs are unused, and no timer or position registers are built.

## Test plan
All scenarios use BASE_CYCLES=10, STEP_CYCLES=2, POS_W=8, CNT_W=12, BTN_RATE=4.
- Direct mode, PAD1_POS=5, PAD2_POS=0, one PAD_TRG_N fall: PAD1_OUT high after edge n+2 for exactly 20 cycles; PAD2_OUT high for 10 cycles, starting on the same edge.
- Second fall 8 cycles into a PAD1_POS=5 pulse: the pulse is still 20 cycles. A fall after the pulse ends and after trigger high for ≥2 cycles starts a new 20-cycle pulse.
- PAD_TRG_N held low 100 cycles with PAD1_POS=255: exactly one pulse of 520 cycles; no further pulse until the next fall.
- Change PAD1_POS from 5 to 200 mid-pulse: the current pulse stays 20 cycles; the next pulse is 410 cycles.
- RESET_N low during a pulse: PAD1_OUT=PAD2_OUT=0 without waiting for a clock; no pulse after release until a new fall.
- PAD_BUTTON_EN: after reset the position is 128. Hold PAD1_DN_N low for 40 cycles, giving 10 steps to 138, then trigger: 286-cycle pulse. UP and DN held together leave the position unchanged. UP held for 600 cycles saturates at 0, giving a 10-cycle pulse.
